// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch sequencer: FSM encoding,
// PC reset value and default bus widths.
package fetch_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t S_IDLE = 3'd0;
  localparam fetch_state_t S_REQ  = 3'd1;
  localparam fetch_state_t S_ADV  = 3'd2;
  localparam fetch_state_t S_HOLD = 3'd3;
  localparam fetch_state_t S_ERR  = 3'd4;

endpackage

// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: PC update, instruction memory, branch redirect and
// the instruction-register handoff to decode.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] pc_in;
  logic              pc_write_en;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_new;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              ir_valid;
  logic [DATA_W-1:0] ir_instr;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_ready;
  logic              fetch_err;

  modport master (
    input  pc_in, imem_ack, imem_rdata, branch_taken, branch_target, ir_ready,
    output pc_write_en, pc_load, pc_new, imem_req, imem_addr,
           ir_valid, ir_instr, ir_pc, fetch_err
  );

  modport slave (
    output pc_in, imem_ack, imem_rdata, branch_taken, branch_target, ir_ready,
    input  pc_write_en, pc_load, pc_new, imem_req, imem_addr,
           ir_valid, ir_instr, ir_pc, fetch_err
  );

endinterface

// File: rtl/fetch_watchdog.sv
// Memory-request watchdog: counts consecutive request cycles without an ack
// and flags expiry on the TIMEOUT_CYC-th such cycle.
module fetch_watchdog
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = i_tick && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer between the PC register, instruction memory and
// decode. Optional memory timeout is enabled with `define FETCH_TIMEOUT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.master bus
);

  fetch_state_t      r_state;
  logic              r_valid;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_ir_pc;

  logic w_in_req;
  logic w_in_adv;
  logic w_branch;
  logic w_capture;
  logic w_expire;

  assign w_in_req = (r_state == S_REQ);
  assign w_in_adv = (r_state == S_ADV);

`ifdef FETCH_TIMEOUT_EN
  logic r_err;

  // A hung memory parks the unit in S_ERR, where redirects are ignored.
  assign w_branch = bus.branch_taken && (r_state != S_ERR);

  fetch_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (!w_in_req || w_branch),
    .i_tick   (w_in_req && !bus.imem_ack),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_expire && !w_branch) begin
      r_err <= 1'b1;
    end
  end

  assign bus.fetch_err = r_err;
`else
  assign w_branch      = bus.branch_taken;
  assign w_expire      = 1'b0;
  assign bus.fetch_err = 1'b0;
`endif

  assign bus.imem_req    = w_in_req;
  assign bus.imem_addr   = w_in_req ? bus.pc_in : '0;
  assign bus.pc_write_en = w_branch || w_in_adv;
  assign bus.pc_load     = w_branch;
  assign bus.pc_new      = w_branch ? bus.branch_target : '0;

  assign bus.ir_valid = r_valid;
  assign bus.ir_instr = r_instr;
  assign bus.ir_pc    = r_ir_pc;

  // A redirect in the ack cycle discards the returned word.
  assign w_capture = w_in_req && bus.imem_ack && !w_branch;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_ir_pc <= ADDR_W'(PC_RESET);
    end else if (w_branch) begin
      r_state <= S_REQ;
      r_valid <= 1'b0;
    end else begin
      if (w_capture) begin
        r_valid <= 1'b1;
        r_instr <= bus.imem_rdata;
        r_ir_pc <= bus.pc_in;
      end else if (r_valid && bus.ir_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (bus.imem_ack) begin
            r_state <= S_ADV;
          end else if (w_expire) begin
            r_state <= S_ERR;
          end
        end
        S_ADV:  r_state <= bus.ir_ready ? S_REQ : S_HOLD;
        S_HOLD: begin
          if (bus.ir_ready) begin
            r_state <= S_REQ;
          end
        end
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed handshake/branch/timeout steps, then random
// memory latency, decode stalls and redirects checked against a slot/PC model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // PC register the unit drives
  logic [31:0] pc;
  always @(posedge clk) begin
    if (reset) pc <= 32'h0;
    else if (bus.pc_write_en) pc <= bus.pc_load ? bus.pc_new : pc + 32'd4;
  end
  assign bus.pc_in = pc;

  // Instruction memory: fixed latency, random latency, or never answers
  int mem_lat   = 0;
  bit mem_rand  = 1'b0;
  bit mem_never = 1'b0;
  int wait_cnt  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0001 + a;
  endfunction

  always @(negedge clk) begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    if (reset || !bus.imem_req) begin
      wait_cnt = 0;
    end else if (!mem_never &&
                 (mem_rand ? ($urandom_range(0, 3) != 0) : (wait_cnt >= mem_lat))) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = mem_word(bus.imem_addr);
      wait_cnt       = 0;
    end else begin
      wait_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  int          n_we;
  int          n_deliv;
  bit          slot;
  bit          ack_prev;
  bit          ack_now;
  bit          br;
  logic [31:0] exp_pc;
  logic [31:0] tgt;

  initial begin
    bus.ir_ready      = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", bus.ir_valid, 0);
    chk("rst_instr", bus.ir_instr, 0);
    chk("rst_pc", bus.ir_pc, 0);
    chk("rst_err", bus.fetch_err, 0);
    chk("rst_req", bus.imem_req, 0);
    reset = 1'b0;

    // zero-wait fetch at pc 0
    nxt();
    chk("t1_req", bus.imem_req, 1);
    chk("t1_addr", bus.imem_addr, 32'h0);
    chk("t1_we_early", bus.pc_write_en, 0);
    nxt();
    chk("t1_valid", bus.ir_valid, 1);
    chk("t1_irpc", bus.ir_pc, 32'h0);
    chk("t1_instr", bus.ir_instr, 32'hA000_0001);
    chk("t1_we", bus.pc_write_en, 1);
    chk("t1_load", bus.pc_load, 0);
    nxt();
    chk("t1_we_pulse", bus.pc_write_en, 0);
    chk("t1_next_addr", bus.imem_addr, 32'h4);
    chk("t1_valid_clr", bus.ir_valid, 0);
    mem_lat = 3;

    // ack delayed 3 cycles at pc 8
    nxt();
    n_we = 0;
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("t2_req", bus.imem_req, 1);
      chk("t2_addr", bus.imem_addr, 32'h8);
      n_we += int'(bus.pc_write_en);
    end
    nxt();
    n_we += int'(bus.pc_write_en);
    chk("t2_valid", bus.ir_valid, 1);
    chk("t2_irpc", bus.ir_pc, 32'h8);
    mem_lat = 0;
    nxt();
    n_we += int'(bus.pc_write_en);
    chk("t2_we_pulses", n_we, 1);
    chk("t2_next_addr", bus.imem_addr, 32'hC);
    bus.ir_ready = 1'b0;

    // decode stalls for 5 cycles after capture
    nxt();
    chk("t3_valid", bus.ir_valid, 1);
    chk("t3_irpc", bus.ir_pc, 32'hC);
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("t3_hold_req", bus.imem_req, 0);
      chk("t3_hold_valid", bus.ir_valid, 1);
      chk("t3_hold_instr", bus.ir_instr, 32'hA000_000D);
      chk("t3_hold_we", bus.pc_write_en, 0);
    end
    @(negedge clk);
    bus.ir_ready = 1'b1;
    #1;
    chk("t3_still_hold", bus.imem_req, 0);
    nxt();
    chk("t3_resume_req", bus.imem_req, 1);
    chk("t3_resume_addr", bus.imem_addr, 32'h10);

    // branch during the advance cycle
    @(negedge clk);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h100;
    bus.ir_ready      = 1'b0;
    #1;
    chk("t4_valid_pre", bus.ir_valid, 1);
    chk("t4_load", bus.pc_load, 1);
    chk("t4_new", bus.pc_new, 32'h100);
    chk("t4_we", bus.pc_write_en, 1);
    @(negedge clk);
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.ir_ready      = 1'b1;
    #1;
    chk("t4_valid_clr", bus.ir_valid, 0);
    chk("t4_req", bus.imem_req, 1);
    chk("t4_addr", bus.imem_addr, 32'h100);
    chk("t4_load_idle", bus.pc_load, 0);
    chk("t4_new_idle", bus.pc_new, 32'h0);
    nxt();
    chk("t4_irpc", bus.ir_pc, 32'h100);
    chk("t4_instr", bus.ir_instr, 32'hA000_0101);

    // branch coincident with ack: word dropped, refetch at target
    @(negedge clk);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h200;
    #1;
    chk("t5_addr", bus.imem_addr, 32'h104);
    chk("t5_load", bus.pc_load, 1);
    @(negedge clk);
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    #1;
    chk("t5_valid_drop", bus.ir_valid, 0);
    chk("t5_req", bus.imem_req, 1);
    chk("t5_addr_tgt", bus.imem_addr, 32'h200);
    nxt();
    chk("t5_valid", bus.ir_valid, 1);
    chk("t5_irpc", bus.ir_pc, 32'h200);
    chk("t5_instr", bus.ir_instr, 32'hA000_0201);
    mem_never = 1'b1;

    // memory never answers
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      nxt();
      chk("t6_wait_req", bus.imem_req, 1);
      chk("t6_wait_err", bus.fetch_err, 0);
    end
    nxt();
    chk("t6_err", bus.fetch_err, 1);
    chk("t6_req_off", bus.imem_req, 0);
    @(negedge clk);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h300;
    #1;
    chk("t6_br_we", bus.pc_write_en, 0);
    chk("t6_br_load", bus.pc_load, 0);
    @(negedge clk);
    bus.branch_taken = 1'b0;
    #1;
    chk("t6_stuck_req", bus.imem_req, 0);
    chk("t6_sticky", bus.fetch_err, 1);
`else
    for (int i = 0; i < 20; i++) begin
      nxt();
      chk("t6_wait_req", bus.imem_req, 1);
      chk("t6_wait_addr", bus.imem_addr, 32'h204);
      chk("t6_no_err", bus.fetch_err, 0);
    end
`endif
    reset = 1'b1;
    nxt();
    chk("t6_rst_err", bus.fetch_err, 0);
    chk("t6_rst_req", bus.imem_req, 0);
    chk("t6_rst_valid", bus.ir_valid, 0);

    // random latency, stalls and redirects
    mem_never = 1'b0;
    mem_rand  = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    exp_pc   = 32'h0;
    slot     = 1'b0;
    ack_prev = 1'b0;
    n_deliv  = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      bus.ir_ready = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 15) == 0);
      tgt = 32'($urandom_range(0, 1023)) << 2;
      bus.branch_taken  = br;
      bus.branch_target = br ? tgt : 32'($urandom);
      #1;
      chk("rnd_req", bus.imem_req, !slot);
      chk("rnd_addr", bus.imem_addr, slot ? 32'h0 : pc);
      chk("rnd_valid", bus.ir_valid, slot);
      chk("rnd_we", bus.pc_write_en, br || ack_prev);
      chk("rnd_load", bus.pc_load, br);
      chk("rnd_new", bus.pc_new, br ? tgt : 32'h0);
      chk("rnd_err", bus.fetch_err, 0);
      if (!br && slot && bus.ir_ready) begin
        chk("rnd_irpc", bus.ir_pc, exp_pc);
        chk("rnd_instr", bus.ir_instr, mem_word(exp_pc));
        n_deliv++;
        exp_pc = exp_pc + 32'd4;
      end
      ack_now = bus.imem_ack && !slot;
      if (br) begin
        slot     = 1'b0;
        ack_prev = 1'b0;
        exp_pc   = tgt;
      end else begin
        ack_prev = ack_now;
        if (ack_now) slot = 1'b1;
        else if (slot && bus.ir_ready) slot = 1'b0;
      end
    end
    chk("rnd_progress", n_deliv >= 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch sequencer directly downstream of the program counter register.
- Reads pc, runs a req/ack handshake with instruction memory, and latches the returned word into a single-entry instruction register with valid/ready toward decode.
- Drives the PC's write_en/load/new_pc: one increment pulse per fetched instruction; branch redirects from execute are passed through.

Parameters:
- ADDR_W, 32, width of pc and memory address
- DATA_W, 32, instruction word width
- TIMEOUT_CYC, 16, max cycles in S_REQ without ack (used only with FETCH_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; same net as PC reset
- pc_in  in  ADDR_W  current pc from PC register
- pc_write_en  out  1  PC update enable (combinational)
- pc_load  out  1  select new_pc over +4 (combinational)
- pc_new  out  ADDR_W  redirect target (combinational)
- imem_req  out  1  memory read request
- imem_addr  out  ADDR_W  read address
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  DATA_W  instruction word
- branch_taken  in  1  single-cycle redirect pulse from execute
- branch_target  in  ADDR_W  redirect address
- ir_valid  out  1  instruction register holds a valid entry
- ir_instr  out  DATA_W  fetched instruction
- ir_pc  out  ADDR_W  address of ir_instr
- ir_ready  in  1  decode accepts entry this cycle
- fetch_err  out  1  sticky memory timeout flag

Behaviour:
- Reset: state=S_IDLE; ir_valid=0, ir_instr=0, ir_pc=0, fetch_err=0, imem_req=0. Reset asserted mid-transaction aborts it; no pending entry survives.
- Reset wins over all other inputs.
- States:
  - S_IDLE: one cycle, then S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc_in, held stable until ack. On imem_ack: ir_instr<=imem_rdata, ir_pc<=pc_in, ir_valid<=1, go to S_ADV. Ack in the same cycle as req is legal.
  - S_ADV: pc_write_en=1, pc_load=0. Go to S_REQ if ir_ready, else S_HOLD.
  - S_HOLD: go to S_REQ when ir_ready.
- Timing: ack in cycle N gives ir_valid and pc_write_en high in N+1, and the new pc is visible in N+2. With zero-wait memory, peak throughput is one instruction per 2 cycles.
- ir_valid clears on ir_valid && ir_ready unless a capture occurs the same cycle. S_REQ is entered only when the slot is free, so a capture never overwrites a valid entry.
- Branch (any state, reset excluded):
  - Same cycle: pc_write_en=1, pc_load=1, pc_new=branch_target. The load overrides the S_ADV increment.
  - Next edge: ir_valid<=0; an imem_ack in the same cycle is discarded; next state S_REQ.
  - Memory tolerates imem_req withdrawal.
- When branch_taken=0, pc_new=0 and pc_load=0.
- imem_addr is driven only in S_REQ and is 0 otherwise. No alignment check; pc_in[1:0] is passed through.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to S_REQ and increments each S_REQ cycle without ack.
  - When it reaches TIMEOUT_CYC: fetch_err<=1 (sticky), state goes to S_ERR, imem_req=0, pc_write_en=0; branches are ignored.
  - Only reset leaves S_ERR.
- Undefined: no counter, no S_ERR; fetch_err tied 0.

Decomposition:
- Package fetch_pkg:
  - state encoding localparams: S_IDLE, S_REQ, S_ADV, S_HOLD, S_ERR
  - PC_RESET=32'h0000_0000
  - default ADDR_W/DATA_W
- Sub-module fetch_watchdog (counter plus compare, instantiated only under FETCH_TIMEOUT_EN). Everything else stays in fetch_unit.

Test Plan:
- Reset, then zero-wait memory returning 32'hA000_0001 at pc 0, ir_ready=1 -> ir_valid high 1 cycle after ack with ir_pc=0; pc_write_en one pulse; next imem_addr=4.
- Ack delayed 3 cycles -> imem_req and imem_addr=8 held stable for 4 cycles; exactly one pc_write_en pulse.
- ir_ready=0 for 5 cycles after capture -> state S_HOLD, ir_instr stable, imem_req=0; ir_ready=1 -> req resumes at the next pc.
- branch_taken with branch_target=32'h100 during S_ADV -> pc_load=1 and pc_new=32'h100 that cycle; ir_valid cleared; next imem_addr=32'h100.
- branch_taken coincident with imem_ack -> data dropped, ir_valid=0, refetch at target.
- FETCH_TIMEOUT_EN, no ack for 16 cycles -> fetch_err=1 and imem_req=0 thereafter; reset clears fetch_err.
